sub32_serial: RTL

//   Digit-serial 32-bit subtractor, the inverse arithmetic path to the datapath adder.

---
 rtl/sub32_serial.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sub32_serial.sv
// sub32_serial -- digit-serial subtractor (DIFF = A - B mod 2^WIDTH).
//
// Purpose:
//   Computes A - B as A + ~B + 1, DIGIT bits per clock, LSB first.
//   It uses a start/busy/done handshake. The operation takes N = WIDTH/DIGIT
//   digit cycles, followed by a one-cycle done pulse. The block reports the
//   unsigned borrow and the signed overflow.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only when not busy (IDLE or DONE)
//   a      in   WIDTH  minuend, captured on accepted start
//   b      in   WIDTH  subtrahend, captured on accepted start
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse, diff/borrow/ovf valid
//   diff   out  WIDTH  A - B, held until the next completion
//   borrow out  1      A < B (unsigned)
//   ovf    out  1      signed overflow
//   zero   out  1      diff == 0 (only with SUB32_SERIAL_ZERO_FLAG_EN)
//
// Configuration:
//   SUB32_SERIAL_ZERO_FLAG_EN -- when defined, adds the 'zero' output.
//   'zero' is derived from a running all-zero accumulator that is updated
//   per digit.

module sub32_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
`ifdef SUB32_SERIAL_ZERO_FLAG_EN
  output logic             ovf,
  output logic             zero
`else
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;

  logic [DIGIT-1:0] a_sl_s;
  logic [DIGIT-1:0] b_sl_s;
  logic [DIGIT:0]   sum_s;
  logic [DIGIT-1:0] dig_s;
  logic             c_s;
  logic [WIDTH-1:0] res_next_s;
  logic             accept_s;
  logic             last_s;

  // Current digit slice: the operand registers are shifted right every
  // digit cycle, so the active slice is always in the low bits.
  always_comb begin
    a_sl_s = a_r[DIGIT-1:0];
    b_sl_s = b_r[DIGIT-1:0];
    sum_s  = {1'b0, a_sl_s} + {1'b0, ~b_sl_s} + {{DIGIT{1'b0}}, carry_r};
    dig_s  = sum_s[DIGIT-1:0];
    c_s    = sum_s[DIGIT];
  end

  // The result digit enters from the MSB side. After N shifts, the first
  // digit has reached the LSB position.
  generate
    if (N == 1) begin : g_res_one
      assign res_next_s = dig_s;
    end else begin : g_res_many
      assign res_next_s = {dig_s, res_r[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign last_s   = (cnt_r == CNT_LAST);

`ifdef SUB32_SERIAL_ZERO_FLAG_EN
  logic zacc_r;

  // Running all-zero accumulator. 'zero' is taken from it together with the
  // final digit, so no full-width compare is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zacc_r <= 1'b0;
      zero   <= 1'b0;
    end else if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      if (accept_s) begin
        zacc_r <= 1'b1;
      end
    end else if (state_r == ST_RUN) begin
      zacc_r <= zacc_r & (dig_s == {DIGIT{1'b0}});
      if (last_s) begin
        zero <= zacc_r & (dig_s == {DIGIT{1'b0}});
      end
    end
  end
`endif

  // Control FSM and datapath registers. The outputs change only on the last
  // digit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      carry_r <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= {WIDTH{1'b0}};
      borrow  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= 1'b1;             // the +1 of the two's complement of B
            cnt_r   <= {CNT_W{1'b0}};
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          carry_r <= c_s;
          res_r   <= res_next_s;
          if (last_s) begin
            // The final slice holds the sign bits of A, B and diff.
            diff    <= res_next_s;
            borrow  <= ~c_s;
            ovf     <= (a_sl_s[DIGIT-1] != b_sl_s[DIGIT-1]) &&
                       (dig_s[DIGIT-1] != a_sl_s[DIGIT-1]);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
